// File: rtl/rr_pkg.sv
// Shared constants, channel-index type and one-hot decode for the rr_req_agent slice.
package rr_pkg;

    localparam int unsigned NUM_CH         = 4;
    localparam int unsigned DEF_DATA_W     = 8;
    localparam int unsigned DEF_DEPTH      = 4;
    localparam int unsigned DEF_STARVE_LIM = 15;

    typedef logic [1:0] ch_idx_t;

    // Returns the index of the lowest set bit; zero when no bit is set.
    function automatic ch_idx_t onehot_to_idx(input logic [NUM_CH-1:0] oh);
        ch_idx_t idx;
        idx = '0;
        for (int unsigned i = NUM_CH; i > 0; i--) begin
            if (oh[i-1]) begin
                idx = ch_idx_t'(i - 1);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_chan_fifo.sv
// Single-channel FIFO with occupancy count; push refused when full, pop ignored when empty.
module rr_chan_fifo
    import rr_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_head,
    output logic              o_full,
    output logic              o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule

// File: rtl/rr_req_agent.sv
// Four-channel request agent: per-channel FIFOs feeding an external round-robin arbiter.
// Optional per-channel served counters are enabled by defining RR_REQ_STATS_EN.
module rr_req_agent
    import rr_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned STARVE_LIM = DEF_STARVE_LIM
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        push_valid,
    input  logic [NUM_CH*DATA_W-1:0] push_data,
    output logic [NUM_CH-1:0]        push_ready,
    output logic [NUM_CH-1:0]        req,
    input  logic [NUM_CH-1:0]        gnt,
    output logic                     out_valid,
    output logic [1:0]               out_ch,
    output logic [DATA_W-1:0]        out_data,
    output logic [NUM_CH-1:0]        starve,
`ifdef RR_REQ_STATS_EN
    output logic [NUM_CH*8-1:0]      served_cnt,
`endif
    output logic                     proto_err
);

    localparam int unsigned WAIT_W = $clog2(STARVE_LIM + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIM);

    logic [DATA_W-1:0] w_head [NUM_CH];
    logic [NUM_CH-1:0] w_full;
    logic [NUM_CH-1:0] w_empty;
    logic [NUM_CH-1:0] w_gnt_req;
    logic [NUM_CH-1:0] w_pop;
    logic              w_proto_viol;
    ch_idx_t           w_sel_idx;

    logic              r_out_valid;
    ch_idx_t           r_out_ch;
    logic [DATA_W-1:0] r_out_data;
    logic              r_proto_err;
    logic [NUM_CH-1:0] r_starve;
    logic [WAIT_W-1:0] r_wait     [NUM_CH];
    logic [WAIT_W-1:0] w_wait_nxt [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        rr_chan_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk         (clk),
            .reset       (reset),
            .i_push      (push_valid[g]),
            .i_push_data (push_data[g*DATA_W +: DATA_W]),
            .i_pop       (w_pop[g]),
            .o_head      (w_head[g]),
            .o_full      (w_full[g]),
            .o_empty     (w_empty[g])
        );
    end

    assign push_ready = ~w_full;
    assign req        = ~w_empty;
    assign w_gnt_req  = gnt & req;

    // Only the lowest granted non-empty channel is popped; extra or empty grants are errors.
    always_comb begin
        logic found;
        w_pop = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (w_gnt_req[i] && !found) begin
                w_pop[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign w_proto_viol = ($countones(gnt) > 1) || ((gnt & ~req) != '0);
    assign w_sel_idx    = onehot_to_idx(w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_out_data  <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_out_valid <= |w_pop;
            if (|w_pop) begin
                r_out_ch   <= w_sel_idx;
                r_out_data <= w_head[w_sel_idx];
            end
            if (w_proto_viol) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_wait_nxt[i] = r_wait[i];
            if (w_pop[i] || !req[i]) begin
                w_wait_nxt[i] = '0;
            end else if (!gnt[i] && (r_wait[i] != WAIT_MAX)) begin
                w_wait_nxt[i] = r_wait[i] + WAIT_W'(1);
            end
        end
    end

    // starve is registered off the next wait value so it tracks the counter without lag.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (reset) begin
                r_wait[i]   <= '0;
                r_starve[i] <= 1'b0;
            end else begin
                r_wait[i]   <= w_wait_nxt[i];
                r_starve[i] <= (w_wait_nxt[i] == WAIT_MAX);
            end
        end
    end

`ifdef RR_REQ_STATS_EN
    logic [7:0] r_served [NUM_CH];

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (reset) begin
                r_served[i] <= '0;
            end else if (w_pop[i] && (r_served[i] != '1)) begin
                r_served[i] <= r_served[i] + 8'd1;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_stat
        assign served_cnt[g*8 +: 8] = r_served[g];
    end
`endif

    assign out_valid = r_out_valid;
    assign out_ch    = r_out_ch;
    assign out_data  = r_out_data;
    assign starve    = r_starve;
    assign proto_err = r_proto_err;

endmodule

// File: doc/rr_req_agent.md
RR_REQ_AGENT -- requirements
Module: rr_req_agent

Interface
REQ-001 Parameter DATA_W, default 8, payload width per channel.
REQ-002 Parameter DEPTH, default 4, entries per channel FIFO (power of two, >=2).
REQ-003 Parameter STARVE_LIM, default 15, wait cycles before the starvation flag sets.
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 push_valid  input  4  per-channel write strobe.
REQ-007 push_data  input  4*DATA_W  channel i payload in bits [i*DATA_W +: DATA_W].
REQ-008 push_ready  output  4  channel i FIFO not full.
REQ-009 req  output  4  request vector to the round-robin arbiter; bit i = channel i FIFO non-empty.
REQ-010 gnt  input  4  grant vector from the arbiter, expected one-hot or zero.
REQ-011 out_valid  output  1  registered, one cycle per dequeued entry.
REQ-012 out_ch  output  2  channel index of the out_data entry.
REQ-013 out_data  output  DATA_W  dequeued payload.
REQ-014 starve  output  4  channel i waited STARVE_LIM cycles without a grant.
REQ-015 proto_err  output  1  sticky protocol-violation flag.

Function
REQ-016 Per channel: FIFO of DEPTH x DATA_W with wr/rd pointers and a DEPTH-range (log2(DEPTH)+1 bit) occupancy count; pointers wrap modulo DEPTH.
REQ-017 Push accepted when push_valid[i] && push_ready[i]; push_ready[i] = (count[i] != DEPTH) from registered state only, so a full FIFO refuses a push even on a cycle it pops.
REQ-018 req[i] = (count[i] != 0), combinational from registered count, no dependence on gnt.
REQ-019 Valid grant: exactly one gnt bit set, at channel i with req[i]=1; that cycle pop head of channel i.
REQ-020 Next cycle: out_valid=1, out_ch=i, out_data=popped entry (latency 1); otherwise out_valid=0, out_ch/out_data hold.
REQ-021 Simultaneous push and pop on one non-full channel: both happen, count unchanged.
REQ-022 gnt with >1 bit set: serve lowest-indexed granted channel with req=1, set proto_err.
REQ-023 gnt bit set on channel with req=0: no pop, set proto_err; other granted bits handled per REQ-022.
REQ-024 proto_err clears only on reset.
REQ-025 Per-channel wait counter: increments while req[i]=1 and gnt[i]=0, saturates at STARVE_LIM, clears on pop of channel i or when req[i]=0.
REQ-026 starve[i] = (wait[i] == STARVE_LIM), registered; drops the cycle after channel i is served.

Reset
REQ-027 On reset all FIFOs flush (pointers, counts = 0); reset overrides any same-cycle push or grant.
REQ-028 Reset values: req=0, push_ready=4'b1111 after the reset cycle, out_valid=0, out_ch=0, out_data=0, starve=0, proto_err=0, wait counters 0.
REQ-029 Reset mid-transfer discards all queued entries; no out_valid for entries in flight.

Configuration
REQ-030 Macro RR_REQ_STATS_EN defined: add output served_cnt (4x8 bits), per-channel saturating count of pops, cleared by reset, holds at 255.
REQ-031 Macro undefined: port served_cnt and its counters are absent; all other behaviour identical.

Structure
REQ-032 Shared package rr_pkg: NUM_CH=4, channel-index typedef (2 bits), default DATA_W/DEPTH/STARVE_LIM constants, one-hot-to-index function.
REQ-033 One sub-module rr_chan_fifo (single-channel FIFO with count, full/empty), instantiated 4 times; grant decode, output register, wait counters and error logic in the top.

Verification
REQ-034 Push 0xA1,0xA2 to ch2, gnt=4'b0100 two cycles -> req[2] high then low, out_valid two cycles, out_ch=2, out_data 0xA1 then 0xA2.
REQ-035 Fill ch0 with 4 entries -> push_ready[0]=0; fifth push with simultaneous grant -> rejected, 4 entries still output in order.
REQ-036 ch1 empty, gnt=4'b0010 -> no out_valid, proto_err=1 and stays 1 until reset.
REQ-037 ch0 and ch3 non-empty, gnt=4'b1001 -> ch0 served, ch3 count unchanged, proto_err=1.
REQ-038 ch3 holds entry, gnt=0 for 15 cycles -> starve[3]=1 at 15th wait; grant ch3 -> starve[3]=0 next cycle.
REQ-039 Three entries queued on ch1, reset asserted one cycle -> req=0, out_valid=0, all outputs at reset values; subsequent grant produces no output.
